sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, width of the SRAM word address.
REQ-002 Parameter WAIT_CYCLES, default 2, number of cycles SRAM strobes are held per access; legal range 1..15.
REQ-003 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 inst_ce_i  input  1  instruction-fetch request, held until inst_ready_o.
REQ-006 inst_addr_i  input  32  fetch byte address.
REQ-007 inst_data_o  output  32  fetched instruction word, registered.
REQ-008 inst_ready_o  output  1  one-cycle completion pulse for fetch.
REQ-009 data_ce_i  input  1  data-access request, held until data_ready_o.
REQ-010 data_we_i  input  1  1 = write, 0 = read.
REQ-011 data_addr_i  input  32  data byte address.
REQ-012 data_sel_i  input  4  byte lane enables for writes.
REQ-013 data_wdata_i  input  32  write data.
REQ-014 data_rdata_o  output  32  read data, registered.
REQ-015 data_ready_o  output  1  one-cycle completion pulse for data.
REQ-016 stallreq_o  output  1  pipeline stall request to ctrl.
REQ-017 sram_addr_o  output  ADDR_W  SRAM word address.
REQ-018 sram_wdata_o  output  32  SRAM write data.
REQ-019 sram_rdata_i  input  32  SRAM read data.
REQ-020 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  output  1 each  active-low SRAM strobes.
REQ-021 sram_be_n_o  output  4  active-low SRAM byte enables.

Function
REQ-022 FSM states: IDLE, ACCESS, RESP; owner register records INST or DATA.
REQ-023 IDLE: data_ce_i=1 grants DATA; else inst_ce_i=1 grants INST; else stay IDLE. When both are requested, DATA wins.
REQ-024 On grant, register address, write data, byte enables and direction; move to ACCESS; load the wait counter to WAIT_CYCLES-1.
REQ-025 sram_addr_o = registered byte address bits [ADDR_W+1:2]; bits [1:0] ignored.
REQ-026 ACCESS: sram_ce_n_o=0 every cycle. Reads: sram_oe_n_o=0, sram_be_n_o=4'b0000. Writes: sram_we_n_o=0, sram_be_n_o=~data_sel_i registered. Counter decrements each cycle.
REQ-027 ACCESS, counter=0: capture sram_rdata_i into the owner's data register (reads only), then go to RESP.
REQ-028 RESP: all strobes high; the owner's ready output = 1 for exactly this cycle; next state IDLE.
REQ-029 Latency from request sampled in IDLE to ready pulse = WAIT_CYCLES+1 cycles; one access per WAIT_CYCLES+2 cycles minimum.
REQ-030 Fetches are always reads; data_we_i is ignored for INST.
REQ-031 Requests are not sampled in ACCESS or RESP; a request arriving there waits for IDLE.
REQ-032 Requester drops ce mid-access: the access completes and ready still pulses; no abort.
REQ-033 inst_data_o/data_rdata_o hold their last value until the next completed read by the same owner; writes leave data_rdata_o unchanged.
REQ-034 stallreq_o = (data_ce_i & ~data_ready_o) | (inst_ce_i & ~inst_ready_o), combinational.
REQ-035 Strobe outputs and sram_addr_o/sram_wdata_o are registered (glitch-free) and stable for the whole ACCESS window.

Reset
REQ-036 On rst=0, asynchronously: state IDLE, counter 0, all sram_*_n_o = 1, sram_be_n_o = 4'hF, sram_addr_o/sram_wdata_o = 0, ready outputs 0, inst_data_o/data_rdata_o = 0.
REQ-037 Reset asserted mid-access aborts immediately with outputs as in REQ-036; no ready pulse follows the deassertion of reset.

Verification (WAIT_CYCLES=2)
REQ-038 Fetch only: inst_ce_i=1, addr 0x0000_0010, SRAM word 4 = 0x2401_0005 -> oe_n/ce_n low for 2 cycles, sram_addr_o=4, inst_ready_o pulses in cycle 3, inst_data_o=0x2401_0005.
REQ-039 Simultaneous fetch and data read in the same cycle -> DATA served first (data_ready_o cycle 3), INST granted on the next IDLE, inst_ready_o 4 cycles later; stallreq_o high throughout.
REQ-040 Byte write: data_we_i=1, addr 0x0000_0101, sel 4'b0010, wdata 0x0000_AB00 -> sram_addr_o=0x40, sram_be_n_o=4'b1101, we_n low 2 cycles, data_rdata_o unchanged.
REQ-041 Reset mid-ACCESS -> all strobes high the same cycle; after release, no ready pulse and state IDLE.
REQ-042 Fetch ce dropped during ACCESS -> inst_ready_o still pulses once; the next IDLE cycle idles with no SRAM strobes.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master (fetch/data) arbiter for a single-port asynchronous SRAM
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ce_i,
    input  logic [31:0]       inst_addr_i,
    output logic [31:0]       inst_data_o,
    output logic              inst_ready_o,
    input  logic              data_ce_i,
    input  logic              data_we_i,
    input  logic [31:0]       data_addr_i,
    input  logic [3:0]        data_sel_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       data_rdata_o,
    output logic              data_ready_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic       OWN_INST = 1'b0;
    localparam logic       OWN_DATA = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant;
    logic        done;
    logic [31:0] req_addr;
    logic [3:0]  req_be_n;
    logic        unused_addr_bits;

    // Only the word-address bits reach the SRAM; byte offset and high bits are dropped.
    assign unused_addr_bits = ^{inst_addr_i, data_addr_i};

    // Last ACCESS cycle: sample read data and raise the owner's ready next cycle.
    assign done = (state_q == ACCESS) && (cnt_q == 4'd0);

    // Requester's own view of stalling: pending request not yet completed.
    assign stallreq_o = (data_ce_i & ~data_ready_o) | (inst_ce_i & ~inst_ready_o);

    // Request mux for the grant cycle; data port has priority over fetch.
    assign req_addr = data_ce_i ? data_addr_i : inst_addr_i;
    assign req_be_n = (data_ce_i && data_we_i) ? ~data_sel_i : 4'b0000;

    // Next-state logic: grant in IDLE, count down in ACCESS, single RESP cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_ce_i) begin
                    grant   = 1'b1;
                    owner_d = OWN_DATA;
                    we_d    = data_we_i;
                end else if (inst_ce_i) begin
                    grant   = 1'b1;
                    owner_d = OWN_INST;
                    we_d    = 1'b0;
                end
                if (grant) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and access-attribute registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_INST;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // SRAM pins driven from flops so strobes are glitch-free across the ACCESS window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr_o  <= '0;
            sram_wdata_o <= 32'd0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_be_n_o  <= 4'hF;
        end else begin
            if (grant) begin
                sram_addr_o <= req_addr[ADDR_W+1:2];
                sram_be_n_o <= req_be_n;
                if (data_ce_i) begin
                    sram_wdata_o <= data_wdata_i;
                end
            end else if (state_d != ACCESS) begin
                sram_be_n_o <= 4'hF;
            end
            sram_ce_n_o <= ~(state_d == ACCESS);
            sram_oe_n_o <= ~((state_d == ACCESS) && !we_d);
            sram_we_n_o <= ~((state_d == ACCESS) && we_d);
        end
    end

    // Completion pulses and per-owner read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_ready_o <= 1'b0;
            data_ready_o <= 1'b0;
            inst_data_o  <= 32'd0;
            data_rdata_o <= 32'd0;
        end else begin
            inst_ready_o <= done && (owner_q == OWN_INST);
            data_ready_o <= done && (owner_q == OWN_DATA);
            if (done && !we_q) begin
                if (owner_q == OWN_INST) begin
                    inst_data_o <= sram_rdata_i;
                end else begin
                    data_rdata_o <= sram_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_ce_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        inst_ready_o;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        stallreq_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [3:0]  sram_be_n_o;

    int vectors;
    int miscompares;

    logic [31:0] mem [0:255];

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_ce_i    (inst_ce_i),
        .inst_addr_i  (inst_addr_i),
        .inst_data_o  (inst_data_o),
        .inst_ready_o (inst_ready_o),
        .data_ce_i    (data_ce_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_sel_i   (data_sel_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_ready_o (data_ready_o),
        .stallreq_o   (stallreq_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
        .sram_ce_n_o  (sram_ce_n_o),
        .sram_oe_n_o  (sram_oe_n_o),
        .sram_we_n_o  (sram_we_n_o),
        .sram_be_n_o  (sram_be_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: drives the addressed word while output-enabled.
    assign sram_rdata_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_strobes(input string name, input logic ce_n, input logic oe_n,
                                 input logic we_n, input logic [3:0] be_n);
        vectors++;
        if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o} !== {ce_n, oe_n, we_n, be_n}) begin
            miscompares++;
            $display("FAIL %s: ce_n/oe_n/we_n/be_n got %b/%b/%b/%b expected %b/%b/%b/%b", name,
                     sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, ce_n, oe_n, we_n, be_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        check_strobes("reset_strobes", 1'b1, 1'b1, 1'b1, 4'hF);
        check32("reset_addr", {12'd0, sram_addr_o}, 32'd0);
        check32("reset_wdata", sram_wdata_o, 32'd0);
        check1("reset_inst_ready", inst_ready_o, 1'b0);
        check1("reset_data_ready", data_ready_o, 1'b0);
        check32("reset_inst_data", inst_data_o, 32'd0);
        check32("reset_data_rdata", data_rdata_o, 32'd0);
        check1("reset_stall", stallreq_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h0000_0010;
        #1;
        check1("fetch_stall_req", stallreq_o, 1'b1);
        for (int c = 1; c <= 2; c++) begin
            tick();
            check_strobes($sformatf("fetch_access_c%0d", c), 1'b0, 1'b0, 1'b1, 4'b0000);
            check32($sformatf("fetch_addr_c%0d", c), {12'd0, sram_addr_o}, 32'd4);
            check1($sformatf("fetch_noready_c%0d", c), inst_ready_o, 1'b0);
        end
        tick();
        check1("fetch_ready_c3", inst_ready_o, 1'b1);
        check32("fetch_data", inst_data_o, 32'h2401_0005);
        check_strobes("fetch_resp_strobes", 1'b1, 1'b1, 1'b1, 4'hF);
        check1("fetch_stall_at_ready", stallreq_o, 1'b0);
        inst_ce_i = 1'b0;
        tick();
        check1("fetch_ready_pulse_end", inst_ready_o, 1'b0);
    endtask

    task automatic test_priority();
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h0000_0014;
        data_ce_i   = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h0000_0020;
        data_sel_i  = 4'hF;
        for (int c = 1; c <= 2; c++) begin
            tick();
            check32($sformatf("prio_data_addr_c%0d", c), {12'd0, sram_addr_o}, 32'd8);
            check1($sformatf("prio_stall_c%0d", c), stallreq_o, 1'b1);
        end
        tick();
        check1("prio_data_ready_c3", data_ready_o, 1'b1);
        check1("prio_inst_not_ready_c3", inst_ready_o, 1'b0);
        check32("prio_data_rdata", data_rdata_o, 32'h1111_2222);
        check1("prio_stall_c3", stallreq_o, 1'b1);
        data_ce_i = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            tick();
            check1($sformatf("prio_inst_wait_c%0d", c), inst_ready_o, 1'b0);
            check1($sformatf("prio_stall_c%0d", c), stallreq_o, 1'b1);
        end
        check32("prio_inst_addr", {12'd0, sram_addr_o}, 32'd5);
        tick();
        check1("prio_inst_ready_c7", inst_ready_o, 1'b1);
        check32("prio_inst_data", inst_data_o, 32'hCAFE_0001);
        check32("prio_data_rdata_held", data_rdata_o, 32'h1111_2222);
        inst_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_byte_write();
        data_ce_i    = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h0000_0101;
        data_sel_i   = 4'b0010;
        data_wdata_i = 32'h0000_AB00;
        for (int c = 1; c <= 2; c++) begin
            tick();
            check_strobes($sformatf("wr_access_c%0d", c), 1'b0, 1'b1, 1'b0, 4'b1101);
            check32($sformatf("wr_addr_c%0d", c), {12'd0, sram_addr_o}, 32'h40);
            check32($sformatf("wr_wdata_c%0d", c), sram_wdata_o, 32'h0000_AB00);
        end
        tick();
        check1("wr_ready_c3", data_ready_o, 1'b1);
        check_strobes("wr_resp_strobes", 1'b1, 1'b1, 1'b1, 4'hF);
        check32("wr_rdata_unchanged", data_rdata_o, 32'h1111_2222);
        data_ce_i = 1'b0;
        data_we_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h0000_0010;
        tick();
        check1("rstmid_in_access", sram_ce_n_o, 1'b0);
        rst = 1'b0;
        #1;
        check_strobes("rstmid_async_strobes", 1'b1, 1'b1, 1'b1, 4'hF);
        check32("rstmid_async_addr", {12'd0, sram_addr_o}, 32'd0);
        check32("rstmid_inst_data", inst_data_o, 32'd0);
        inst_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check1($sformatf("rstmid_no_ready_c%0d", c), inst_ready_o, 1'b0);
            check1($sformatf("rstmid_idle_c%0d", c), sram_ce_n_o, 1'b1);
        end
    endtask

    task automatic test_ce_drop();
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h0000_0010;
        tick();
        inst_ce_i = 1'b0;
        check1("drop_access_c1", sram_ce_n_o, 1'b0);
        tick();
        check1("drop_access_c2", sram_oe_n_o, 1'b0);
        tick();
        check1("drop_ready_c3", inst_ready_o, 1'b1);
        check32("drop_data", inst_data_o, 32'h2401_0005);
        tick();
        check1("drop_ready_once", inst_ready_o, 1'b0);
        check_strobes("drop_idle_c4", 1'b1, 1'b1, 1'b1, 4'hF);
        tick();
        check_strobes("drop_idle_c5", 1'b1, 1'b1, 1'b1, 4'hF);
        check1("drop_idle_noready_c5", inst_ready_o, 1'b0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]       = 32'h2401_0005;
        mem[5]       = 32'hCAFE_0001;
        mem[8]       = 32'h1111_2222;
        rst          = 1'b1;
        inst_ce_i    = 1'b0;
        inst_addr_i  = 32'h0;
        data_ce_i    = 1'b0;
        data_we_i    = 1'b0;
        data_addr_i  = 32'h0;
        data_sel_i   = 4'h0;
        data_wdata_i = 32'h0;
        #2;
        test_reset();
        test_fetch();
        test_priority();
        test_byte_write();
        test_reset_mid_access();
        test_ce_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
